// File: rtl/layer_xfer_sequencer.sv
// layer_xfer_sequencer
// Walks a DIM x DIM x NCH feature map in x-fastest, then y, then channel order.
// Each step issues a source read and, RD_LAT cycles later, the matching
// destination write together with its flattened linear index.
// A low i_wr_ready freezes the whole walk, so no item is lost or duplicated.
// A one-cycle o_done pulse follows the final write.
module layer_xfer_sequencer #(
  parameter int DIM    = 13,
  parameter int NCH    = 16,
  parameter int IDX_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_wr_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_src_rd_en,
  output logic [IDX_W-1:0] o_src_x,
  output logic [IDX_W-1:0] o_src_y,
  output logic [IDX_W-1:0] o_src_ch,
  output logic             o_dst_wr_en,
  output logic [IDX_W-1:0] o_dst_x,
  output logic [IDX_W-1:0] o_dst_y,
  output logic [IDX_W-1:0] o_dst_ch,
  output logic [IDX_W-1:0] o_dst_lin
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] XY_MAX = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] CH_MAX = IDX_W'(NCH - 1);
  localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

  logic [1:0]       r_state;

  // Source-side walk counters; r_lin tracks the flattened index of (x,y,ch).
  logic [IDX_W-1:0] r_x;
  logic [IDX_W-1:0] r_y;
  logic [IDX_W-1:0] r_ch;
  logic [IDX_W-1:0] r_lin;

  // Read-latency pipeline: stage 0 is the newest, stage RD_LAT-1 drives the write.
  logic [RD_LAT-1:0] r_vld;
  logic [IDX_W-1:0]  r_px   [RD_LAT];
  logic [IDX_W-1:0]  r_py   [RD_LAT];
  logic [IDX_W-1:0]  r_pch  [RD_LAT];
  logic [IDX_W-1:0]  r_plin [RD_LAT];

  logic w_active;
  logic w_adv;
  logic w_issue;
  logic w_start_ok;
  logic w_x_last;
  logic w_y_last;
  logic w_ch_last;
  logic w_last_item;
  logic w_upper_empty;
  logic w_drain_done;

  // The walk only moves in RUN/DRAIN, only when the destination is ready,
  // and never in a cycle that is being aborted.
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_adv       = w_active && i_wr_ready && !i_abort;
  assign w_issue     = (r_state == S_RUN) && i_wr_ready && !i_abort;
  assign w_start_ok  = (r_state == S_IDLE) && i_start && !i_abort;

  assign w_x_last    = (r_x == XY_MAX);
  assign w_y_last    = (r_y == XY_MAX);
  assign w_ch_last   = (r_ch == CH_MAX);
  assign w_last_item = w_x_last && w_y_last && w_ch_last;

  // True when every stage except the write stage is empty.
  always_comb begin
    w_upper_empty = 1'b1;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (r_vld[i]) w_upper_empty = 1'b0;
    end
  end

  // Drain completes once the pipeline will be empty after this edge.
  assign w_drain_done = (r_vld == '0) || (w_adv && w_upper_empty);

  // Control FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE, abort returns to IDLE.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_abort)                      r_state <= S_IDLE;
          else if (w_issue && w_last_item)  r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (i_abort)           r_state <= S_IDLE;
          else if (w_drain_done) r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Coordinate walk: x fastest, then y, then channel; wraps to zero after the last item.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_ch  <= '0;
      r_lin <= '0;
    end else if (w_start_ok) begin
      r_x   <= '0;
      r_y   <= '0;
      r_ch  <= '0;
      r_lin <= '0;
    end else if (w_issue) begin
      r_lin <= w_last_item ? '0 : r_lin + ONE;
      if (!w_x_last) begin
        r_x <= r_x + ONE;
      end else begin
        r_x <= '0;
        if (!w_y_last) begin
          r_y <= r_y + ONE;
        end else begin
          r_y  <= '0;
          r_ch <= w_ch_last ? '0 : r_ch + ONE;
        end
      end
    end
  end

  // Pipeline valids: shift on advance, flush on abort or outside RUN/DRAIN.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vld <= '0;
    end else if (i_abort || !w_active) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Pipeline payload: coordinates and linear index travel with their valid bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_px[i]   <= '0;
        r_py[i]   <= '0;
        r_pch[i]  <= '0;
        r_plin[i] <= '0;
      end
    end else if (w_adv) begin
      r_px[0]   <= r_x;
      r_py[0]   <= r_y;
      r_pch[0]  <= r_ch;
      r_plin[0] <= r_lin;
      for (int i = 1; i < RD_LAT; i++) begin
        r_px[i]   <= r_px[i-1];
        r_py[i]   <= r_py[i-1];
        r_pch[i]  <= r_pch[i-1];
        r_plin[i] <= r_plin[i-1];
      end
    end
  end

  // Strobes are register bits qualified by the same-cycle ready/abort,
  // so a stall cycle carries no read and no write.
  assign o_busy      = w_active;
  assign o_done      = (r_state == S_DONE);
  assign o_src_rd_en = w_issue;
  assign o_src_x     = r_x;
  assign o_src_y     = r_y;
  assign o_src_ch    = r_ch;
  assign o_dst_wr_en = r_vld[RD_LAT-1] && w_adv;
  assign o_dst_x     = r_px[RD_LAT-1];
  assign o_dst_y     = r_py[RD_LAT-1];
  assign o_dst_ch    = r_pch[RD_LAT-1];
  assign o_dst_lin   = r_plin[RD_LAT-1];

endmodule
